// File: rtl/jogador_automatico.sv
// jogador_automatico: records the game's one-hot LED sequence and replays it as timed button presses.
// Optional JOGADOR_ERRO_EN adds input erro_pos; the press at that replay index is rotated left (wrong move).
module jogador_automatico #(
  parameter int T_PRESS = 20,
  parameter int T_GAP   = 80,
  parameter int DEPTH   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] leds,
  input  logic       vez,
`ifdef JOGADOR_ERRO_EN
  input  logic [3:0] erro_pos,
`endif
  output logic [3:0] botoes,
  output logic       ocupado,
  output logic       fim_replay,
  output logic [4:0] num_jogadas,
  output logic       cheio,
  output logic       erro_captura,
  output logic [2:0] db_estado
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = AW + 1;

  typedef enum logic [2:0] {
    ESPERA    = 3'd0,
    CAPTURA   = 3'd1,
    PRESSIONA = 3'd2,
    SOLTA     = 3'd3,
    FIM       = 3'd4
  } estado_t;

  estado_t       r_estado;
  logic [3:0]    r_leds_prev;
  logic [3:0]    r_botoes;
  logic          r_fim;
  logic [4:0]    r_num;
  logic          r_erro;
  logic [7:0]    r_timer;
  logic [IW-1:0] r_idx;
  logic [1:0]    r_mem [DEPTH];

  logic          w_edge;
  logic          w_onehot;
  logic          w_cheio;
  logic          w_wr_en;
  logic [1:0]    w_code;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_rd_addr;
  logic [3:0]    w_dec;
  logic [3:0]    w_press;

  assign w_edge    = (r_leds_prev == 4'b0000) && (leds != 4'b0000);
  assign w_onehot  = (leds & (leds - 4'd1)) == 4'b0000;
  assign w_cheio   = r_num == 5'(DEPTH);
  assign w_code    = {leds[3] | leds[2], leds[3] | leds[1]};
  assign w_wr_en   = !iniciar && w_edge && w_onehot &&
                     (r_estado == ESPERA || (r_estado == CAPTURA && !w_cheio));
  assign w_wr_addr = (r_estado == ESPERA) ? '0 : r_num[AW-1:0];
  // Address of the entry about to be pressed: 0 when starting, idx+1 when leaving a gap.
  assign w_rd_addr = (r_estado == SOLTA) ? AW'(r_idx + IW'(1)) : '0;
  assign w_dec     = 4'b0001 << r_mem[w_rd_addr];
`ifdef JOGADOR_ERRO_EN
  assign w_press   = (((r_estado == SOLTA) ? 5'(r_idx) + 5'd1 : 5'd0) == {1'b0, erro_pos}) ?
                     {w_dec[2:0], w_dec[3]} : w_dec;
`else
  assign w_press   = w_dec;
`endif

  always_ff @(posedge clock)
    if (w_wr_en) r_mem[w_wr_addr] <= w_code;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado    <= ESPERA;
      r_leds_prev <= 4'b0000;
      r_botoes    <= 4'b0000;
      r_fim       <= 1'b0;
      r_num       <= 5'd0;
      r_erro      <= 1'b0;
      r_timer     <= 8'd0;
      r_idx       <= '0;
    end else begin
      r_leds_prev <= leds;
      r_fim       <= 1'b0;
      if (iniciar) begin
        r_estado <= ESPERA;
        r_botoes <= 4'b0000;
        r_num    <= 5'd0;
        r_erro   <= 1'b0;
        r_timer  <= 8'd0;
        r_idx    <= '0;
      end else begin
        if (w_edge && !w_onehot) r_erro <= 1'b1;
        if (w_wr_en) r_num <= (r_estado == ESPERA) ? 5'd1 : r_num + 5'd1;
        case (r_estado)
          ESPERA:
            if (w_wr_en) r_estado <= CAPTURA;
            else if (vez && r_num == 5'd0) begin
              r_estado <= FIM;
              r_fim    <= 1'b1;
            end
          CAPTURA:
            if (vez) begin
              r_estado <= PRESSIONA;
              r_idx    <= '0;
              r_timer  <= 8'(T_PRESS - 1);
              r_botoes <= w_press;
            end
          PRESSIONA:
            if (r_timer == 8'd0) begin
              r_estado <= SOLTA;
              r_timer  <= 8'(T_GAP - 1);
              r_botoes <= 4'b0000;
            end else r_timer <= r_timer - 8'd1;
          SOLTA:
            if (r_timer != 8'd0) r_timer <= r_timer - 8'd1;
            else if (5'(r_idx) == r_num - 5'd1) begin
              r_estado <= FIM;
              r_fim    <= 1'b1;
            end else begin
              r_estado <= PRESSIONA;
              r_idx    <= r_idx + IW'(1);
              r_timer  <= 8'(T_PRESS - 1);
              r_botoes <= w_press;
            end
          default: r_estado <= ESPERA;
        endcase
      end
    end
  end

  assign botoes       = r_botoes;
  assign ocupado      = r_estado == CAPTURA || r_estado == PRESSIONA || r_estado == SOLTA;
  assign fim_replay   = r_fim;
  assign num_jogadas  = r_num;
  assign cheio        = w_cheio;
  assign erro_captura = r_erro;
  assign db_estado    = r_estado;
endmodule

// File: tb/tb_jogador_automatico.sv
// tb_jogador_automatico: directed capture/replay/abort/reset sequence for jogador_automatico.
module tb_jogador_automatico;
`ifdef JOGADOR_ERRO_EN
  localparam bit ERRO = 1'b1;
`else
  localparam bit ERRO = 1'b0;
`endif
  logic       clock = 1'b0;
  logic       reset, iniciar, vez;
  logic [3:0] leds;
  logic [3:0] erro_pos = 4'hF;
  logic [3:0] botoes;
  logic       ocupado, fim_replay, cheio, erro_captura;
  logic [4:0] num_jogadas;
  logic [2:0] db_estado;

  int n_pass = 0, n_tot = 0;
  logic [3:0] pv[$];
  int pl[$], gl[$];
  int nfim, first_b, first_st;
  logic [3:0] ov [18] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2,
                          4'h8, 4'h1, 4'h4, 4'h4, 4'h1, 4'h8, 4'h2, 4'h1, 4'h8};

  jogador_automatico dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .leds(leds), .vez(vez),
`ifdef JOGADOR_ERRO_EN
    .erro_pos(erro_pos),
`endif
    .botoes(botoes), .ocupado(ocupado), .fim_replay(fim_replay),
    .num_jogadas(num_jogadas), .cheio(cheio), .erro_captura(erro_captura),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] expv(input int i, input logic [3:0] v);
    return (ERRO && i == int'(erro_pos)) ? {v[2:0], v[3]} : v;
  endfunction

  task automatic edge_in(input logic [3:0] v);
    leds = v;
    cyc(2);
    leds = 4'b0000;
    cyc(2);
  endtask

  // Raises vez for one cycle, then logs every press value/length and gap length until back in ESPERA.
  task automatic replay(input int budget);
    logic [3:0] cur;
    int run;
    bit done;
    pv.delete(); pl.delete(); gl.delete();
    nfim = 0; cur = 4'b0000; run = 0; done = 1'b0;
    vez = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      cyc(1);
      if (i == 0) begin
        first_b = int'(botoes);
        first_st = int'(db_estado);
        vez = 1'b0;
      end
      if (fim_replay) nfim++;
      if (botoes !== cur) begin
        if (cur != 4'b0000) begin
          pv.push_back(cur);
          pl.push_back(run);
        end else if (pv.size() > 0) gl.push_back(run);
        cur = botoes;
        run = 1;
      end else run++;
      if (nfim > 0 && db_estado == 3'd0) done = 1'b1;
    end
    chk("replay_done", 32'(done), 32'd1);
  endtask

  initial begin
    int nb, nf;
    reset = 1'b0; iniciar = 1'b0; vez = 1'b0; leds = 4'b0000;
    cyc(2);
    chk("rst_botoes", 32'(botoes), 32'h0);
    chk("rst_estado", 32'(db_estado), 32'd0);
    chk("rst_num", 32'(num_jogadas), 32'd0);
    chk("rst_cheio", 32'(cheio), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_erro", 32'(erro_captura), 32'd0);
    chk("rst_fim", 32'(fim_replay), 32'd0);
    reset = 1'b1;
    cyc(1);

    leds = 4'b0001; cyc(10);
    chk("cap1_estado", 32'(db_estado), 32'd1);
    chk("cap1_num", 32'(num_jogadas), 32'd1);
    chk("cap1_ocupado", 32'(ocupado), 32'd1);
    leds = 4'b0000; cyc(10);
    leds = 4'b0010; cyc(10);
    leds = 4'b0000; cyc(10);
    leds = 4'b0100; cyc(10);
    leds = 4'b0000; cyc(10);
    chk("cap3_num", 32'(num_jogadas), 32'd3);
    replay(1000);
    chk("r3_first_botoes", 32'(first_b), 32'h1);
    chk("r3_first_estado", 32'(first_st), 32'd2);
    chk("r3_npress", 32'(pv.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("r3_val%0d", i), 32'(pv[i]), 32'(expv(i, 4'b0001 << i)));
      chk($sformatf("r3_len%0d", i), 32'(pl[i]), 32'd20);
    end
    for (int i = 0; i < 2; i++) chk($sformatf("r3_gap%0d", i), 32'(gl[i]), 32'd80);
    chk("r3_nfim", 32'(nfim), 32'd1);
    chk("r3_num_kept", 32'(num_jogadas), 32'd3);

    leds = 4'b0011; cyc(2);
    leds = 4'b0000; cyc(2);
    chk("inv_erro", 32'(erro_captura), 32'd1);
    chk("inv_num", 32'(num_jogadas), 32'd3);
    chk("inv_estado", 32'(db_estado), 32'd0);
    iniciar = 1'b1; cyc(1); iniciar = 1'b0;
    chk("ini_erro", 32'(erro_captura), 32'd0);
    chk("ini_num", 32'(num_jogadas), 32'd0);
    vez = 1'b1; cyc(1); vez = 1'b0;
    chk("empty_fim", 32'(fim_replay), 32'd1);
    chk("empty_estado", 32'(db_estado), 32'd4);
    chk("empty_botoes", 32'(botoes), 32'h0);
    cyc(1);
    chk("empty_fim_once", 32'(fim_replay), 32'd0);
    chk("empty_back", 32'(db_estado), 32'd0);

    for (int i = 0; i < 18; i++) begin
      edge_in(ov[i]);
      if (i == 14) chk("ov15_cheio", 32'(cheio), 32'd0);
      if (i == 15) chk("ov16_cheio", 32'(cheio), 32'd1);
    end
    chk("ov_num", 32'(num_jogadas), 32'd16);
    chk("ov_cheio", 32'(cheio), 32'd1);
    replay(2500);
    chk("ov_npress", 32'(pv.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ov_val%0d", i), 32'(pv[i]), 32'(expv(i, ov[i])));
      chk($sformatf("ov_len%0d", i), 32'(pl[i]), 32'd20);
    end
    for (int i = 0; i < 15; i++) chk($sformatf("ov_gap%0d", i), 32'(gl[i]), 32'd80);
    chk("ov_nfim", 32'(nfim), 32'd1);

    edge_in(4'b1000);
    edge_in(4'b0001);
    chk("ab_num", 32'(num_jogadas), 32'd2);
    vez = 1'b1; cyc(1); vez = 1'b0;
    chk("ab_press1", 32'(botoes), 32'(expv(0, 4'b1000)));
    cyc(100);
    chk("ab_press2", 32'(botoes), 32'(expv(1, 4'b0001)));
    cyc(5);
    iniciar = 1'b1; cyc(1); iniciar = 1'b0;
    chk("ab_botoes", 32'(botoes), 32'h0);
    chk("ab_num0", 32'(num_jogadas), 32'd0);
    chk("ab_estado", 32'(db_estado), 32'd0);
    nb = 0; nf = 0;
    for (int i = 0; i < 150; i++) begin
      cyc(1);
      if (fim_replay) nf++;
      if (botoes != 4'b0000) nb++;
    end
    chk("ab_no_fim", 32'(nf), 32'd0);
    chk("ab_no_press", 32'(nb), 32'd0);

    edge_in(4'b0100);
    vez = 1'b1; cyc(1); vez = 1'b0;
    cyc(5);
    chk("mid_botoes", 32'(botoes), 32'(expv(0, 4'b0100)));
    chk("mid_estado", 32'(db_estado), 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("async_botoes", 32'(botoes), 32'h0);
    chk("async_estado", 32'(db_estado), 32'd0);
    cyc(2);
    chk("mrst_botoes", 32'(botoes), 32'h0);
    chk("mrst_estado", 32'(db_estado), 32'd0);
    chk("mrst_num", 32'(num_jogadas), 32'd0);
    reset = 1'b1;
    cyc(1);

`ifdef JOGADOR_ERRO_EN
    erro_pos = 4'd1;
    edge_in(4'b0001);
    edge_in(4'b1000);
    replay(1000);
    chk("err_npress", 32'(pv.size()), 32'd2);
    chk("err_val0", 32'(pv[0]), 32'h1);
    chk("err_val1", 32'(pv[1]), 32'h1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
